// File: rtl/demux_scheduler_pkg.sv
// Shared constants and types for the demux scheduler slice.
//   NUM_OUT / SEL_W : output channel count and channel-index width
//   CNT_W           : width of the wait and skip counters
//   state_t         : buffer state (EMPTY / HOLD)
//   MODE_RR/ADDR    : capture mode encodings
package demux_pkg;

  localparam int unsigned NUM_OUT = 8;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned CNT_W   = 8;

  localparam logic MODE_RR   = 1'b0;
  localparam logic MODE_ADDR = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Next channel in round-robin order; wraps 7 -> 0 through truncation.
  function automatic logic [SEL_W-1:0] next_chan(input logic [SEL_W-1:0] chan);
    return chan + SEL_W'(1);
  endfunction

endpackage

// File: rtl/demux_scheduler_if.sv
// Producer-side stream and consumer-side demux bus of the scheduler.
//   in_valid/in_ready/in_data/in_mode/in_dest : input word stream
//   out_valid/out_ready/out_data              : one-hot output channels on a shared bus
//   sel/skip_cnt                              : current target channel, timeout-skip count
// slave  : the scheduler's view
// master : the surrounding producer/consumer view
interface demux_scheduler_if
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) ();

  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic                in_mode;
  logic [SEL_W-1:0]    in_dest;
  logic [NUM_OUT-1:0]  out_valid;
  logic [NUM_OUT-1:0]  out_ready;
  logic [DATA_W-1:0]   out_data;
  logic [SEL_W-1:0]    sel;
  logic [CNT_W-1:0]    skip_cnt;

  modport slave (
    input  in_valid, in_data, in_mode, in_dest, out_ready,
    output in_ready, out_valid, out_data, sel, skip_cnt
  );

  modport master (
    output in_valid, in_data, in_mode, in_dest, out_ready,
    input  in_ready, out_valid, out_data, sel, skip_cnt
  );

endinterface

// File: rtl/demux_scheduler_demux.sv
// 1-to-8 decoder: routes the single-bit din onto output bit sel.
//   sel  : channel index
//   din  : bit to route
//   dout : one-hot (or all zero when din is low)
module demux
  import demux_pkg::*;
(
  input  logic [SEL_W-1:0]   sel,
  input  logic               din,
  output logic [NUM_OUT-1:0] dout
);

  always_comb begin
    dout      = '0;
    dout[sel] = din;
  end

endmodule

// File: rtl/demux_scheduler.sv
// One-entry buffered scheduler feeding eight consumers over a shared data bus.
// Words are captured from a valid/ready stream and delivered either to the
// channel named with the word or to the next round-robin channel; round-robin
// words that stall for TIMEOUT cycles are moved to the following channel.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : demux_scheduler_if slave modport (stream in, one-hot channels out)
module demux_scheduler
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 4
) (
  input logic               clk,
  input logic               rst,
  demux_scheduler_if.slave  bus
);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SKIP_MAX  = '1;

  state_t              state_q,    state_d;
  logic [DATA_W-1:0]   data_q,     data_d;
  logic                mode_q,     mode_d;
  logic [SEL_W-1:0]    sel_q,      sel_d;
  logic [SEL_W-1:0]    rr_ptr_q,   rr_ptr_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]    skip_cnt_q, skip_cnt_d;

  logic                deliver;
  logic                capture;
  logic                in_ready_c;
  logic [NUM_OUT-1:0]  out_valid_c;

  // Handshake decode; in_ready is combinational from out_ready for full throughput.
  always_comb begin
    deliver    = (state_q == HOLD) && bus.out_ready[sel_q];
    in_ready_c = !rst && ((state_q == EMPTY) || deliver);
    capture    = bus.in_valid && in_ready_c;
  end

  // Next-state: delivery frees the buffer, capture refills it, stalled
  // round-robin words age toward a skip. Delivery beats a same-cycle timeout.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    mode_d     = mode_q;
    sel_d      = sel_q;
    rr_ptr_d   = rr_ptr_q;
    wait_cnt_d = wait_cnt_q;
    skip_cnt_d = skip_cnt_q;

    if (deliver) begin
      state_d    = EMPTY;
      rr_ptr_d   = next_chan(sel_q);
      wait_cnt_d = '0;
    end

    if (capture) begin
      state_d    = HOLD;
      data_d     = bus.in_data;
      mode_d     = bus.in_mode;
      // Round-robin capture uses the pointer already advanced by a same-cycle delivery.
      sel_d      = (bus.in_mode == MODE_ADDR) ? bus.in_dest : rr_ptr_d;
      wait_cnt_d = '0;
    end else if ((state_q == HOLD) && !deliver && (mode_q == MODE_RR)) begin
      if (wait_cnt_q == WAIT_LAST) begin
        sel_d      = next_chan(sel_q);
        wait_cnt_d = '0;
        if (skip_cnt_q != SKIP_MAX) begin
          skip_cnt_d = skip_cnt_q + CNT_W'(1);
        end
      end else begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      data_q     <= '0;
      mode_q     <= MODE_RR;
      sel_q      <= '0;
      rr_ptr_q   <= '0;
      wait_cnt_q <= '0;
      skip_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      mode_q     <= mode_d;
      sel_q      <= sel_d;
      rr_ptr_q   <= rr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end

  // One-hot channel valid, high only while a word is held.
  demux u_demux (
    .sel  (sel_q),
    .din  (state_q == HOLD),
    .dout (out_valid_c)
  );

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = data_q;
  assign bus.sel       = sel_q;
  assign bus.skip_cnt  = skip_cnt_q;

endmodule

// File: tb/tb_demux_scheduler.sv
// Self-checking bench for demux_scheduler: directed scenarios plus a random
// run, all compared against a word-level reference model of the scheduler.
module tb_demux_scheduler;

  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  demux_scheduler_if #(.DATA_W(DATA_W)) bus ();

  demux_scheduler #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: is a word held, which word, where it is aimed, how long it waited.
  bit         m_full;
  bit         m_mode;
  logic [7:0] m_word;
  int         m_sel;
  int         m_next_rr;
  int         m_waited;
  int         m_skips;

  task automatic model_reset();
    m_full = 0; m_mode = 0; m_word = 8'h00;
    m_sel = 0; m_next_rr = 0; m_waited = 0; m_skips = 0;
  endtask

  function automatic logic [7:0] exp_valid();
    return m_full ? 8'(1 << m_sel) : 8'h00;
  endfunction

  function automatic logic exp_ready();
    return !m_full || bus.out_ready[m_sel];
  endfunction

  task automatic drive(input logic v, input logic [7:0] d, input logic m,
                       input logic [2:0] dst, input logic [7:0] ordy);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_mode   = m;
    bus.in_dest   = dst;
    bus.out_ready = ordy;
  endtask

  // Advance one clock; the model applies the scheduling rules to the inputs seen at the edge.
  task automatic tick();
    bit         took, got;
    logic [7:0] d;
    bit         md;
    int         dst;
    took = m_full && bus.out_ready[m_sel];
    got  = bus.in_valid && (!m_full || took);
    d    = bus.in_data;
    md   = bus.in_mode;
    dst  = int'(bus.in_dest);
    @(posedge clk);
    if (took) begin
      m_full    = 0;
      m_next_rr = (m_sel + 1) % 8;
      m_waited  = 0;
    end
    if (got) begin
      m_full   = 1;
      m_word   = d;
      m_mode   = md;
      m_sel    = md ? dst : m_next_rr;
      m_waited = 0;
    end else if (m_full && !m_mode) begin
      m_waited = m_waited + 1;
      if (m_waited == TIMEOUT) begin
        m_sel    = (m_sel + 1) % 8;
        m_waited = 0;
        if (m_skips < 255) m_skips = m_skips + 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 8'h00, 0, 3'd0, 8'h00);
    model_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.out_valid !== 8'h00) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=%b", bus.out_valid, 8'h00); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    n_cmp++; if (bus.sel !== 3'd0) begin n_bad++; $display("FAIL reset_sel got=%0d exp=0", bus.sel); end
    n_cmp++; if (bus.skip_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_skip got=%0d exp=0", bus.skip_cnt); end
    n_cmp++; if (bus.out_data !== 8'h00) begin n_bad++; $display("FAIL reset_out_data got=%h exp=00", bus.out_data); end
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_rr_sequence();
    for (int i = 0; i < 8; i++) begin
      drive(1, 8'(8'h10 + i), 0, 3'd0, 8'hFF);
      #1;
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rr_in_ready[%0d] got=%b exp=1", i, bus.in_ready); end
      tick();
      n_cmp++; if (bus.out_valid !== 8'(1 << i)) begin n_bad++; $display("FAIL rr_out_valid[%0d] got=%b exp=%b", i, bus.out_valid, 8'(1 << i)); end
      n_cmp++; if (bus.out_data !== 8'(8'h10 + i)) begin n_bad++; $display("FAIL rr_out_data[%0d] got=%h exp=%h", i, bus.out_data, 8'(8'h10 + i)); end
    end
    drive(0, 8'h00, 0, 3'd0, 8'hFF);
    tick();
    n_cmp++; if (bus.out_valid !== 8'h00) begin n_bad++; $display("FAIL rr_drain got=%b exp=0", bus.out_valid); end
    n_cmp++; if (bus.skip_cnt !== 8'd0) begin n_bad++; $display("FAIL rr_skip got=%0d exp=0", bus.skip_cnt); end
    // Pointer wrapped: the next round-robin word targets channel 0.
    drive(1, 8'h20, 0, 3'd0, 8'hFF);
    tick();
    n_cmp++; if (bus.sel !== 3'd0) begin n_bad++; $display("FAIL rr_wrap_sel got=%0d exp=0", bus.sel); end
    drive(0, 8'h00, 0, 3'd0, 8'hFF);
    tick();
  endtask

  task automatic test_addressed_stall();
    int skip0;
    skip0 = m_skips;
    // Every channel except 5 is ready; those bits must be ignored.
    drive(1, 8'hA5, 1, 3'd5, 8'hDF);
    tick();
    drive(0, 8'h00, 0, 3'd0, 8'hDF);
    for (int k = 0; k < 20; k++) begin
      #1;
      n_cmp++; if (bus.out_valid !== 8'b0010_0000) begin n_bad++; $display("FAIL addr_out_valid[%0d] got=%b exp=00100000", k, bus.out_valid); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL addr_in_ready[%0d] got=%b exp=0", k, bus.in_ready); end
      n_cmp++; if (bus.out_data !== 8'hA5) begin n_bad++; $display("FAIL addr_out_data[%0d] got=%h exp=a5", k, bus.out_data); end
      tick();
    end
    drive(0, 8'h00, 0, 3'd0, 8'hFF);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL addr_release_ready got=%b exp=1", bus.in_ready); end
    tick();
    n_cmp++; if (bus.out_valid !== 8'h00) begin n_bad++; $display("FAIL addr_delivered got=%b exp=0", bus.out_valid); end
    n_cmp++; if (int'(bus.skip_cnt) !== skip0) begin n_bad++; $display("FAIL addr_skip got=%0d exp=%0d", bus.skip_cnt, skip0); end
  endtask

  task automatic test_timeout_skip();
    int skip0;
    // Addressed word to channel 1 moves the round-robin pointer to 2.
    drive(1, 8'h31, 1, 3'd1, 8'hFF);
    tick();
    drive(0, 8'h00, 0, 3'd0, 8'hFF);
    tick();
    skip0 = m_skips;
    drive(1, 8'h42, 0, 3'd0, 8'h08);
    tick();
    drive(0, 8'h00, 0, 3'd0, 8'h08);
    for (int k = 0; k < TIMEOUT; k++) begin
      n_cmp++; if (bus.out_valid !== 8'h04) begin n_bad++; $display("FAIL to_wait[%0d] got=%b exp=00000100", k, bus.out_valid); end
      tick();
    end
    n_cmp++; if (bus.out_valid !== 8'h08) begin n_bad++; $display("FAIL to_skipped got=%b exp=00001000", bus.out_valid); end
    n_cmp++; if (int'(bus.skip_cnt) !== skip0 + 1) begin n_bad++; $display("FAIL to_skip_cnt got=%0d exp=%0d", bus.skip_cnt, skip0 + 1); end
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL to_ready got=%b exp=1", bus.in_ready); end
    tick();
    n_cmp++; if (bus.out_valid !== 8'h00) begin n_bad++; $display("FAIL to_delivered got=%b exp=0", bus.out_valid); end
    drive(1, 8'h43, 0, 3'd0, 8'h00);
    tick();
    n_cmp++; if (bus.sel !== 3'd4) begin n_bad++; $display("FAIL to_next_rr got=%0d exp=4", bus.sel); end
    drive(0, 8'h00, 0, 3'd0, 8'hFF);
    tick();
  endtask

  task automatic test_timeout_race();
    int orig, skip0;
    skip0 = m_skips;
    drive(1, 8'h55, 0, 3'd0, 8'h00);
    tick();
    orig = m_sel;
    drive(0, 8'h00, 0, 3'd0, 8'h00);
    repeat (TIMEOUT - 1) tick();
    n_cmp++; if (int'(bus.sel) !== orig) begin n_bad++; $display("FAIL race_sel got=%0d exp=%0d", bus.sel, orig); end
    drive(0, 8'h00, 0, 3'd0, 8'(1 << orig));
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL race_ready got=%b exp=1", bus.in_ready); end
    tick();
    n_cmp++; if (bus.out_valid !== 8'h00) begin n_bad++; $display("FAIL race_delivered got=%b exp=0", bus.out_valid); end
    n_cmp++; if (int'(bus.skip_cnt) !== skip0) begin n_bad++; $display("FAIL race_skip got=%0d exp=%0d", bus.skip_cnt, skip0); end
    drive(1, 8'h56, 0, 3'd0, 8'h00);
    tick();
    n_cmp++; if (int'(bus.sel) !== (orig + 1) % 8) begin n_bad++; $display("FAIL race_next_rr got=%0d exp=%0d", bus.sel, (orig + 1) % 8); end
    drive(0, 8'h00, 0, 3'd0, 8'hFF);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      drive(1, d, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'hFF);
      #1;
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, bus.in_ready); end
      tick();
      n_cmp++; if (bus.out_valid !== exp_valid()) begin n_bad++; $display("FAIL b2b_out_valid[%0d] got=%b exp=%b", i, bus.out_valid, exp_valid()); end
      n_cmp++; if (bus.out_data !== d) begin n_bad++; $display("FAIL b2b_out_data[%0d] got=%h exp=%h", i, bus.out_data, d); end
    end
    drive(0, 8'h00, 0, 3'd0, 8'hFF);
    tick();
  endtask

  task automatic test_random();
    logic [7:0] ordy;
    int r;
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 3));
      ordy = (r == 0) ? 8'hFF : (r == 1) ? 8'($urandom) : 8'h00;
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), ordy);
      #1;
      n_cmp++; if (bus.in_ready !== exp_ready()) begin n_bad++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", i, bus.in_ready, exp_ready()); end
      tick();
      n_cmp++; if (bus.out_valid !== exp_valid()) begin n_bad++; $display("FAIL rnd_out_valid[%0d] got=%b exp=%b", i, bus.out_valid, exp_valid()); end
      n_cmp++; if (int'(bus.sel) !== m_sel) begin n_bad++; $display("FAIL rnd_sel[%0d] got=%0d exp=%0d", i, bus.sel, m_sel); end
      n_cmp++; if (bus.out_data !== m_word) begin n_bad++; $display("FAIL rnd_out_data[%0d] got=%h exp=%h", i, bus.out_data, m_word); end
      n_cmp++; if (int'(bus.skip_cnt) !== m_skips) begin n_bad++; $display("FAIL rnd_skip[%0d] got=%0d exp=%0d", i, bus.skip_cnt, m_skips); end
    end
    drive(0, 8'h00, 0, 3'd0, 8'hFF);
    tick();
  endtask

  task automatic test_skip_saturate();
    drive(1, 8'h77, 0, 3'd0, 8'h00);
    tick();
    drive(0, 8'h00, 0, 3'd0, 8'h00);
    repeat (270 * TIMEOUT) tick();
    n_cmp++; if (bus.skip_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_skip got=%0d exp=255", bus.skip_cnt); end
    n_cmp++; if (bus.out_valid !== exp_valid()) begin n_bad++; $display("FAIL sat_out_valid got=%b exp=%b", bus.out_valid, exp_valid()); end
    drive(0, 8'h00, 0, 3'd0, 8'hFF);
    tick();
    n_cmp++; if (bus.out_valid !== 8'h00) begin n_bad++; $display("FAIL sat_delivered got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_reset_mid_hold();
    drive(1, 8'hEE, 0, 3'd0, 8'h00);
    tick();
    drive(0, 8'h00, 0, 3'd0, 8'h00);
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.out_valid !== 8'h00) begin n_bad++; $display("FAIL mid_rst_out_valid got=%b exp=0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ready got=%b exp=0", bus.in_ready); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (bus.sel !== 3'd0) begin n_bad++; $display("FAIL mid_rst_sel got=%0d exp=0", bus.sel); end
    n_cmp++; if (bus.skip_cnt !== 8'd0) begin n_bad++; $display("FAIL mid_rst_skip got=%0d exp=0", bus.skip_cnt); end
    drive(0, 8'h00, 0, 3'd0, 8'hFF);
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if (bus.out_valid !== 8'h00) begin n_bad++; $display("FAIL mid_rst_ghost[%0d] got=%b exp=0", k, bus.out_valid); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_rr_sequence();
    test_addressed_stall();
    test_timeout_skip();
    test_timeout_race();
    test_back_to_back();
    test_random();
    test_skip_saturate();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
